// File: rtl/bus_rr_arbiter_if.sv
// Bus arbitration signal bundle: per-device request, receiver and FIFO-full lines
// in, one-hot voice grant and owner status out.
interface bus_rr_arbiter_if #(
    parameter int unsigned bus_max_devices = 16
);
    localparam int unsigned ID_W = $clog2(bus_max_devices);

    logic [bus_max_devices-1:0] bus_write_request;
    logic [bus_max_devices-1:0] bus_receiver;
    logic [bus_max_devices-1:0] bus_buffer_full;
    logic [bus_max_devices-1:0] bus_voice;
    logic                       bus_busy;
    logic [ID_W-1:0]            owner_id;
    logic                       forced_release;

    // Arbiter side
    modport master (
        input  bus_write_request,
        input  bus_receiver,
        input  bus_buffer_full,
        output bus_voice,
        output bus_busy,
        output owner_id,
        output forced_release
    );

    // Client / fabric side
    modport slave (
        output bus_write_request,
        output bus_receiver,
        output bus_buffer_full,
        input  bus_voice,
        input  bus_busy,
        input  owner_id,
        input  forced_release
    );
endinterface

// File: rtl/bus_rr_arbiter.sv
// Round-robin tri-state bus arbiter with burst limit, receiver-stall timeout
// and a one-cycle dead slot between bus owners.
module bus_rr_arbiter #(
    parameter int unsigned bus_max_devices = 16,
    parameter int unsigned max_burst       = 16,
    parameter int unsigned stall_timeout   = 64
) (
    input  logic             clk,
    input  logic             reset,
    bus_rr_arbiter_if.master bus
);
    localparam int unsigned N       = bus_max_devices;
    localparam int unsigned ID_W    = $clog2(bus_max_devices);
    localparam int unsigned BURST_W = (max_burst > 0) ? $clog2(max_burst + 1) : 1;
    localparam int unsigned STALL_W = (stall_timeout > 0) ? $clog2(stall_timeout + 1) : 1;

    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(max_burst - 1);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(stall_timeout - 1);
    localparam logic [BURST_W-1:0] BURST_SAT  = '1;
    localparam logic [STALL_W-1:0] STALL_SAT  = '1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t              state,     state_n;
    logic [ID_W-1:0]     ptr,       ptr_n;
    logic [BURST_W-1:0]  burst_cnt, burst_n;
    logic [STALL_W-1:0]  stall_cnt, stall_n;
    logic [N-1:0]        voice_q,   voice_n;
    logic [ID_W-1:0]     owner_q,   owner_n;
    logic                forced_q,  forced_n;
    logic                busy_q;

    logic                win_valid;
    logic [ID_W-1:0]     win_idx;
    logic [ID_W-1:0]     cand;
    logic                owner_req;
    logic                stall;
    logic                burst_hit;
    logic                stall_hit;

    // Cyclic scan starting just past the last owner; device 0 never wins
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned i = 1; i <= N; i++) begin
            cand = ID_W'((32'(ptr) + i) % N);
            if (!win_valid && (cand != '0) && bus.bus_write_request[cand]) begin
                win_valid = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign owner_req = bus.bus_write_request[owner_q];
    assign stall     = |(bus.bus_receiver & bus.bus_buffer_full);
    assign burst_hit = (max_burst != 0) && (burst_cnt == BURST_LAST);
    assign stall_hit = (stall_timeout != 0) && stall && (stall_cnt == STALL_LAST);

    // Next-state and next-output logic
    always_comb begin
        state_n  = state;
        ptr_n    = ptr;
        burst_n  = burst_cnt;
        stall_n  = stall_cnt;
        voice_n  = '0;
        owner_n  = '0;
        forced_n = 1'b0;

        case (state)
            ST_IDLE, ST_RELEASE: begin
                if (win_valid) begin
                    state_n = ST_GRANT;
                    voice_n = N'(1) << win_idx;
                    owner_n = win_idx;
                    burst_n = '0;
                    stall_n = '0;
                end else begin
                    state_n = ST_IDLE;
                end
            end

            ST_GRANT: begin
                if (!owner_req) begin
                    state_n = ST_RELEASE;
                    ptr_n   = owner_q;
                end else if (burst_hit || stall_hit) begin
                    state_n  = ST_RELEASE;
                    ptr_n    = owner_q;
                    forced_n = 1'b1;
                end else begin
                    voice_n = voice_q;
                    owner_n = owner_q;
                    burst_n = (burst_cnt == BURST_SAT) ? burst_cnt : burst_cnt + BURST_W'(1);
                    if (stall) begin
                        stall_n = (stall_cnt == STALL_SAT) ? stall_cnt : stall_cnt + STALL_W'(1);
                    end else begin
                        stall_n = '0;
                    end
                end
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            burst_cnt <= '0;
            stall_cnt <= '0;
            voice_q   <= '0;
            owner_q   <= '0;
            forced_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            burst_cnt <= burst_n;
            stall_cnt <= stall_n;
            voice_q   <= voice_n;
            owner_q   <= owner_n;
            forced_q  <= forced_n;
            busy_q    <= |voice_n;
        end
    end

    assign bus.bus_voice      = voice_q;
    assign bus.bus_busy       = busy_q;
    assign bus.owner_id       = owner_q;
    assign bus.forced_release = forced_q;

endmodule

// File: doc/bus_rr_arbiter.md
# bus_rr_arbiter

Round-robin bus arbiter that shares the tri-state data bus among up to `bus_max_devices-1` writer clients (device 0 is never granted). It samples the one-hot-indexed `write_request` lines, grants `voice` to exactly one device, holds the grant while the device keeps requesting, and forces release when a burst limit or a receiver-stall timeout expires. A single dead cycle between owners prevents drive contention on the bus lines. It replaces the fixed-priority arbitration in the bus fabric.

## Interface
Parameters:
- `bus_max_devices`, 16: number of request/voice lines; bit 0 is reserved and never granted.
- `max_burst`, 16: maximum consecutive grant cycles per tenure; 0 = unlimited.
- `stall_timeout`, 64: consecutive receiver-full cycles before forced release; 0 = disabled.

Ports:
- `clk`  in  1  bus clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `bus_write_request`  in  bus_max_devices  request per device; bit 0 ignored.
- `bus_receiver`  in  bus_max_devices  one-hot target of the current owner.
- `bus_buffer_full`  in  bus_max_devices  per-device receive-FIFO full flags.
- `bus_voice`  out  bus_max_devices  one-hot grant, registered.
- `bus_busy`  out  1  high while any voice bit is high (`|bus_voice`).
- `owner_id`  out  $clog2(bus_max_devices)  binary index of the granted device; 0 when idle.
- `forced_release`  out  1  one-cycle pulse when a tenure ends by burst limit or stall timeout.

## Operation
- State machine: IDLE, GRANT, RELEASE. Registers: `ptr` (last owner, reset 0), `burst_cnt`, `stall_cnt`.
- Winner selection, in IDLE and RELEASE: first device `d` with `bus_write_request[d]=1`, scanning `ptr+1, ptr+2, …` cyclically and skipping bit 0. If there is a winner, go to GRANT with `bus_voice=1<<d`, `owner_id=d`, and both counters cleared. If there is no winner, go to IDLE (from RELEASE) or stay in IDLE.
- GRANT exits, evaluated each cycle in this priority order:
  1. Owner's request low: go to RELEASE.
  2. `max_burst!=0 && burst_cnt==max_burst-1`: go to RELEASE and pulse `forced_release`.
  3. `stall_timeout!=0 && stall_cnt==stall_timeout-1` with a stall this cycle: go to RELEASE and pulse `forced_release`.
  4. Otherwise stay in GRANT, with `burst_cnt+1` and `stall_cnt` updated.
- Stall: `|(bus_receiver & bus_buffer_full)` while in GRANT. A stall cycle increments `stall_cnt`; a non-stall cycle clears it. Stall cycles still count toward `burst_cnt`.
- On every GRANT→RELEASE transition, `ptr<=owner_id`. A preempted device therefore becomes lowest priority.
- RELEASE drives `bus_voice=0` for exactly one cycle and arbitrates in that same cycle.
- Counter widths: $clog2(max_burst+1) and $clog2(stall_timeout+1). Counters saturate and never wrap.
- Reset values: state IDLE, `bus_voice=0`, `bus_busy=0`, `owner_id=0`, `forced_release=0`, `ptr=0`, counters 0.

## Timing
- Grant latency is 1 cycle: a request sampled at edge N in IDLE gives `bus_voice` valid after edge N.
- Release: the owner's request low, sampled at edge N, drops `bus_voice` after edge N (RELEASE).
- Handover: the next owner, chosen from requests sampled at edge N+1, has its voice valid after edge N+1. Exactly 1 idle cycle separates owners; there is never a cycle with two voice bits set.
- Tenure: with `max_burst=B`, a continuous requester holds voice for exactly B cycles.
- `forced_release` rises in the first RELEASE cycle, coincident with `bus_voice` going to 0, and is low otherwise.
- Requests and deassertions during RELEASE are treated exactly as in IDLE.
- Reset asserted mid-grant: `bus_voice=0` after that edge, and arbitration restarts with device 1 highest priority.
- Only bit 0 requesting: the arbiter stays in IDLE.
- An owner whose request falls in the same cycle as a limit hit: this is a normal release, with no `forced_release` pulse.

## Test plan
- Single requester: `req=0x0004` at edge 1 → `voice=0x0004` and `owner_id=2` from edge 1. Drop `req` at edge 6 → `voice=0` at edge 6 and IDLE at edge 7.
- Contention after reset: `req=0x0104` → device 2 granted first. It releases, then 1 dead cycle, then device 8 granted.
- Burst rotation, `max_burst=4`, `req=0x0026` held: grants cycle 1→2→5→1, each exactly 4 cycles, separated by 1 dead cycle. `forced_release` pulses each handover.
- Stall timeout, `stall_timeout=8`, owner 3 targeting device 8 with `bus_buffer_full[8]=1` continuously: release after 8 grant cycles with `forced_release=1`. A single non-full cycle midway restarts the count.
- Reset mid-grant: owner 5 active, `reset=1` for 1 cycle → `voice=0` and `owner_id=0`. With `req=0x0022`, device 1 is granted next.
- Bit 0 only: `req=0x0001` for 20 cycles → `voice` stays 0 and `bus_busy=0`.
